// File: rtl/micro_sequencer_if.sv
// micro_sequencer_if: opcode/ready handshake and decoded control outputs of
// the micro-sequencer. Optional macro SEQ_STEP_EN adds the single-step input.
interface micro_sequencer_if #(
  parameter int OPCODE_W = 4,
  parameter int CYCLE_W  = 4,
  parameter int STATE_W  = 4
);
  logic [OPCODE_W-1:0] opcode;
  logic                ready;
`ifdef SEQ_STEP_EN
  logic                step;
`endif
  logic [STATE_W-1:0]  state;
  logic [CYCLE_W-1:0]  cycle;
  logic                halted;
  logic                instr_done;

`ifdef SEQ_STEP_EN
  modport master (output opcode, ready, step,
                  input  state, cycle, halted, instr_done);
  modport slave  (input  opcode, ready, step,
                  output state, cycle, halted, instr_done);
`else
  modport master (output opcode, ready,
                  input  state, cycle, halted, instr_done);
  modport slave  (input  opcode, ready,
                  output state, cycle, halted, instr_done);
`endif
endinterface

// File: rtl/micro_sequencer.sv
// micro_sequencer: steps through the micro-cycles of one instruction at a
// time, decoding a control state from (cycle, instruction opcode).
// Optional feature: define SEQ_STEP_EN to gate the start of each instruction
// (the c0 advance) on bus.step, allowing one instruction per step pulse.
module micro_sequencer #(
  parameter int OPCODE_W  = 4,
  parameter int CYCLE_W   = 4,
  parameter int STATE_W   = 4,
  parameter int MAX_CYCLE = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  micro_sequencer_if.slave bus
);

  // Control state codes shared with the rest of the controller.
  localparam logic [STATE_W-1:0] ST_FETCH_PC   = STATE_W'(0);
  localparam logic [STATE_W-1:0] ST_FETCH_INST = STATE_W'(1);
  localparam logic [STATE_W-1:0] ST_HALT       = STATE_W'(2);
  localparam logic [STATE_W-1:0] ST_OUT_A      = STATE_W'(3);
  localparam logic [STATE_W-1:0] ST_NEXT       = STATE_W'(4);
  localparam logic [STATE_W-1:0] ST_JUMP_Z     = STATE_W'(5);
  localparam logic [STATE_W-1:0] ST_FETCH_ARG  = STATE_W'(6);
  localparam logic [STATE_W-1:0] ST_LOAD_Z     = STATE_W'(7);
  localparam logic [STATE_W-1:0] ST_RAM_A      = STATE_W'(8);
  localparam logic [STATE_W-1:0] ST_RAM_B      = STATE_W'(9);
  localparam logic [STATE_W-1:0] ST_ALU        = STATE_W'(10);

  // Opcodes with dedicated micro-programs; every other code is an ALU op.
  localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(14);
  localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(15);

  localparam logic [CYCLE_W-1:0] CYC_LAST = CYCLE_W'(MAX_CYCLE);

  logic [CYCLE_W-1:0]  cycle_q, cycle_d;
  logic [OPCODE_W-1:0] ir_op_q, ir_op_d;
  logic                instr_done_q, instr_done_d;
  logic [OPCODE_W-1:0] dec_op;
  logic [STATE_W-1:0]  state_dec;
  logic                step_ok;
  logic                advance;

`ifdef SEQ_STEP_EN
  assign step_ok = bus.step;
`else
  assign step_ok = 1'b1;
`endif

  // Zero-latency decode; fetch cycles look at the live bus opcode because
  // ir_op is only captured when leaving c1. Anything at or past the last
  // legal cycle retires, so the counter can never run off the end.
  always_comb begin
    dec_op    = (cycle_q < CYCLE_W'(2)) ? bus.opcode : ir_op_q;
    state_dec = ST_NEXT;
    if (cycle_q < CYC_LAST) begin
      case (cycle_q)
        CYCLE_W'(0): state_dec = ST_FETCH_PC;
        CYCLE_W'(1): state_dec = ST_FETCH_INST;
        CYCLE_W'(2): begin
          if (dec_op == OP_HLT)      state_dec = ST_HALT;
          else if (dec_op == OP_OUT) state_dec = ST_OUT_A;
          else                       state_dec = ST_FETCH_PC;
        end
        CYCLE_W'(3): begin
          if (dec_op == OP_HLT || dec_op == OP_OUT) state_dec = ST_NEXT;
          else if (dec_op == OP_JMP)                state_dec = ST_JUMP_Z;
          else                                      state_dec = ST_FETCH_ARG;
        end
        CYCLE_W'(4): state_dec = (dec_op == OP_JMP) ? ST_NEXT : ST_LOAD_Z;
        CYCLE_W'(5): state_dec = (dec_op == OP_LDA) ? ST_RAM_A : ST_RAM_B;
        CYCLE_W'(6): state_dec = (dec_op == OP_LDA) ? ST_NEXT : ST_ALU;
        default:     state_dec = ST_NEXT;
      endcase
    end
  end

  // Next-state: HALT freezes the counter; c0 additionally waits for step.
  always_comb begin
    advance      = bus.ready && (state_dec != ST_HALT) &&
                   ((cycle_q != '0) || step_ok);
    cycle_d      = cycle_q;
    ir_op_d      = ir_op_q;
    instr_done_d = 1'b0;
    if (advance) begin
      if (state_dec == ST_NEXT) begin
        cycle_d      = '0;
        instr_done_d = 1'b1;
      end else begin
        cycle_d = cycle_q + CYCLE_W'(1);
      end
      if (cycle_q == CYCLE_W'(1)) ir_op_d = bus.opcode;
    end
  end

  // Sequencer registers; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cycle_q      <= '0;
      ir_op_q      <= '0;
      instr_done_q <= 1'b0;
    end else begin
      cycle_q      <= cycle_d;
      ir_op_q      <= ir_op_d;
      instr_done_q <= instr_done_d;
    end
  end

  assign bus.state      = state_dec;
  assign bus.cycle      = cycle_q;
  assign bus.halted     = (state_dec == ST_HALT);
  assign bus.instr_done = instr_done_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed scenarios plus randomized traffic, checked
// against a micro-program reference model. Honours SEQ_STEP_EN.
module tb_micro_sequencer;

  localparam logic [3:0] S_FETCH_PC = 4'd0, S_FETCH_INST = 4'd1, S_HALT = 4'd2,
                         S_OUT_A = 4'd3, S_NEXT = 4'd4, S_JUMP_Z = 4'd5,
                         S_FETCH_ARG = 4'd6, S_LOAD_Z = 4'd7, S_RAM_A = 4'd8,
                         S_RAM_B = 4'd9, S_ALU = 4'd10;
  localparam logic [3:0] O_LDA = 4'd1, O_ADD = 4'd2, O_JMP = 4'd4,
                         O_OUT = 4'd14, O_HLT = 4'd15;

  logic clk;
  logic reset_n;
  logic step_v;

  micro_sequencer_if #(.OPCODE_W(4), .CYCLE_W(4), .STATE_W(4)) bus ();

  micro_sequencer #(.OPCODE_W(4), .CYCLE_W(4), .STATE_W(4), .MAX_CYCLE(7)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

`ifdef SEQ_STEP_EN
  assign bus.step = step_v;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int dut_done_cnt = 0;

  // Reference model: the whole micro-program of the current instruction as a
  // list of states; the expected cycle is simply the position in that list.
  logic [3:0] prog[$];
  int         idx;
  bit         exp_done;

  task automatic model_reset();
    prog     = '{S_FETCH_PC, S_FETCH_INST};
    idx      = 0;
    exp_done = 1'b0;
  endtask

  task automatic load_prog(input logic [3:0] op);
    prog = '{S_FETCH_PC, S_FETCH_INST};
    case (op)
      O_HLT:   prog.push_back(S_HALT);
      O_OUT:   begin prog.push_back(S_OUT_A); prog.push_back(S_NEXT); end
      O_JMP:   begin prog.push_back(S_FETCH_PC); prog.push_back(S_JUMP_Z);
                     prog.push_back(S_NEXT); end
      O_LDA:   begin prog.push_back(S_FETCH_PC); prog.push_back(S_FETCH_ARG);
                     prog.push_back(S_LOAD_Z); prog.push_back(S_RAM_A);
                     prog.push_back(S_NEXT); end
      default: begin prog.push_back(S_FETCH_PC); prog.push_back(S_FETCH_ARG);
                     prog.push_back(S_LOAD_Z); prog.push_back(S_RAM_B);
                     prog.push_back(S_ALU); prog.push_back(S_NEXT); end
    endcase
  endtask

  task automatic model_edge();
    bit step_now;
`ifdef SEQ_STEP_EN
    step_now = step_v;
`else
    step_now = 1'b1;
`endif
    exp_done = 1'b0;
    if (!reset_n) begin
      model_reset();
    end else if (prog[idx] != S_HALT && bus.ready && (idx != 0 || step_now)) begin
      if (prog[idx] == S_NEXT) begin
        model_reset();
        exp_done = 1'b1;
      end else begin
        if (idx == 1) load_prog(bus.opcode);
        idx++;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},      32'(bus.state),      32'(prog[idx]));
    chk({tag, ".cycle"},      32'(bus.cycle),      32'(idx));
    chk({tag, ".halted"},     32'(bus.halted),     32'(prog[idx] == S_HALT));
    chk({tag, ".instr_done"}, 32'(bus.instr_done), 32'(exp_done));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
    if (bus.instr_done === 1'b1) dut_done_cnt++;
  endtask

  // Called at a falling edge; asserts reset between clock edges.
  task automatic async_reset(input string tag);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all(tag);
  endtask

  initial begin
    reset_n    = 1'b0;
    bus.opcode = '0;
    bus.ready  = 1'b0;
    step_v     = 1'b1;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    check_all("reset_hold");

    // Scenario 1: LDA retires in 7 clocks.
    reset_n = 1'b1; bus.ready = 1'b1; bus.opcode = O_LDA;
    dut_done_cnt = 0;
    repeat (7) tick("s1");
    chk("s1.done_count", 32'(dut_done_cnt), 32'd1);
    chk("s1.cycle_end", 32'(bus.cycle), 32'd0);

    // Scenario 2: ALU op (8 clocks) followed back-to-back by LDA.
    bus.opcode = O_ADD;
    repeat (5) tick("s2a");
    chk("s2.c5_state", 32'(bus.state), 32'(S_RAM_B));
    repeat (3) tick("s2a");
    bus.opcode = O_LDA;
    repeat (7) tick("s2b");
    chk("s2.done_count", 32'(dut_done_cnt), 32'd3);

    // Scenario 3: JMP stalled at c3; opcode churn must not change decode.
    bus.opcode = O_JMP;
    repeat (3) tick("s3");
    chk("s3.c3_state", 32'(bus.state), 32'(S_JUMP_Z));
    bus.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.opcode = 4'($urandom_range(0, 15));
      tick("s3.stall");
    end
    bus.ready = 1'b1;
    tick("s3");
    chk("s3.c4_state", 32'(bus.state), 32'(S_NEXT));
    tick("s3");

    // Scenario 4: HLT parks at c2 until reset.
    bus.opcode = O_HLT;
    repeat (2) tick("s4");
    for (int i = 0; i < 12; i++) begin
      bus.ready = 1'($urandom_range(0, 1));
      tick("s4.halt");
    end
    chk("s4.cycle_held", 32'(bus.cycle), 32'd2);
    chk("s4.halted", 32'(bus.halted), 32'd1);
    async_reset("s4.rst");
    tick("s4.rst_hold");
    reset_n = 1'b1; bus.ready = 1'b1;

    // Scenario 5: asynchronous reset at c5 of an ALU instruction.
    bus.opcode = O_ADD;
    repeat (5) tick("s5");
    chk("s5.at_c5", 32'(bus.cycle), 32'd5);
    async_reset("s5.rst");
    chk("s5.rst_cycle", 32'(bus.cycle), 32'd0);
    tick("s5.rst_hold");
    reset_n = 1'b1;
`ifdef SEQ_STEP_EN
    step_v = 1'b0;
    repeat (3) tick("s5.nostep");
    chk("s5.nostep_cycle", 32'(bus.cycle), 32'd0);
    step_v = 1'b1;
    tick("s5.step");
    chk("s5.step_cycle", 32'(bus.cycle), 32'd1);
    step_v = 1'b0;
    repeat (7) tick("s5.after_step");
`else
    tick("s5.first_adv");
    chk("s5.first_adv_cycle", 32'(bus.cycle), 32'd1);
`endif

    // Randomized traffic with occasional resets (more likely while halted).
    for (int i = 0; i < 400; i++) begin
      bus.opcode = 4'($urandom_range(0, 15));
      bus.ready  = ($urandom_range(0, 3) != 0);
      step_v     = 1'($urandom_range(0, 1));
      if ((prog[idx] == S_HALT && $urandom_range(0, 5) == 0) ||
          $urandom_range(0, 99) == 0) begin
        async_reset("rnd.rst");
        tick("rnd.rst_hold");
        reset_n = 1'b1;
      end else begin
        tick("rnd");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/micro_sequencer.md
MICRO_SEQUENCER -- requirements
Module: micro_sequencer

Interface
REQ-001 Parameter OPCODE_W, default 4: width of the opcode input and of the instruction register.
REQ-002 Parameter CYCLE_W, default 4: width of the micro-cycle counter.
REQ-003 Parameter STATE_W, default 4: width of the state output; codes are taken from the shared parameters include.
REQ-004 Parameter MAX_CYCLE, default 7: last legal micro-cycle; must be less than 2**CYCLE_W.
REQ-005 One clock; reset is asynchronous and active-low.
REQ-006 clk  input  1: rising-edge clock.
REQ-007 reset_n  input  1: asynchronous active-low reset.
REQ-008 opcode  input  OPCODE_W: instruction opcode from the bus, valid during FETCH_INST.
REQ-009 ready  input  1: advance enable; 0 stalls the sequencer in its current micro-cycle.
REQ-010 state  output  STATE_W: control state for the current micro-cycle.
REQ-011 cycle  output  CYCLE_W: current micro-cycle number.
REQ-012 halted  output  1: high while the sequencer sits in HALT.
REQ-013 instr_done  output  1: one-clk pulse after an instruction retires.

Function
REQ-014 An internal cycle register and an internal instruction register ir_op SHALL be held.
- state is a combinational decode of (cycle, ir_op), with zero latency.
REQ-015 Decode SHALL be as follows:
- c0 FETCH_PC; c1 FETCH_INST.
- c2: HLT gives HALT, OUT gives OUT_A, otherwise FETCH_PC.
- c3: HLT or OUT gives NEXT, JMP gives JUMP_Z, otherwise FETCH_ARG.
- c4: JMP gives NEXT, otherwise LOAD_Z.
- c5: LDA gives RAM_A, otherwise RAM_B.
- c6: LDA gives NEXT, otherwise ALU.
- c7 NEXT.
REQ-016 For cycles 0 and 1, state SHALL be decoded using the live opcode input instead of ir_op.
REQ-017 ir_op SHALL load opcode on the clk edge that leaves c1 with ready=1; it holds otherwise.
REQ-018 On a clk edge with ready=1, cycle SHALL increment by 1.
- Exception: if state==NEXT, cycle becomes 0.
REQ-019 Any cycle at or above MAX_CYCLE SHALL decode to NEXT, with no simulation messages, so the counter never wraps.
REQ-020 With ready=0, cycle and ir_op SHALL hold, and state stays stable.
REQ-021 When state==HALT, cycle SHALL hold regardless of ready, and halted=1.
- HALT is left only via reset_n.
REQ-022 instr_done SHALL be registered: high for exactly one clk following the edge that moves cycle from NEXT to 0.
REQ-023 If ready drops during NEXT, instr_done SHALL not pulse until the advancing edge occurs.

Reset
REQ-024 While reset_n=0, cycle SHALL be 0, ir_op 0, halted 0, instr_done 0, and state FETCH_PC.
REQ-025 Reset asserted mid-instruction (including during HALT or a stall) SHALL abort the instruction immediately without an instr_done pulse.
REQ-026 The first advance after reset_n rises SHALL occur on the next clk edge with ready=1.

Configuration
REQ-027 Macro SEQ_STEP_EN SHALL control single-step support.
- When defined: input step (1 bit) is added. At c0 the sequencer advances only on an edge with ready=1 and step=1, so one instruction runs per step pulse; step is ignored in all other cycles.
- When undefined: the step port is absent and behaviour is identical to step tied to 1.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Scenario 1: LDA, ready=1 -> states FETCH_PC, FETCH_INST, FETCH_PC, FETCH_ARG, LOAD_Z, RAM_A, NEXT (7 clks); one instr_done pulse; cycle returns to 0.
- Scenario 2: ALU opcode (e.g. ADD) -> c5 RAM_B, c6 ALU, c7 NEXT; 8 clks to retire; then an LDA follows back-to-back.
- Scenario 3: JMP with ready=0 held for 3 clks at c3 -> JUMP_Z persists 4 clks, then NEXT at c4; opcode changed during the stall does not alter decode.
- Scenario 4: HLT -> HALT at c2; halted=1; cycle stays 2 for more than 10 clks with ready toggling; reset_n low then high -> FETCH_PC, halted=0.
- Scenario 5: reset_n asserted asynchronously at c5 of an ALU instruction -> cycle=0 before the next edge, no instr_done; with SEQ_STEP_EN, no advance past c0 until step=1.
